// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared constants for the Tuse/Tnew hazard unit of the 5-stage pipeline.
//   - fwd_sel_e : D-stage forward-select codes (GRF / E / M / W).
//   - TNEW_*    : result latency, counted from E, for the common result classes.
//   - TUSE_*    : operand consumption point, counted from D.
//   - md_cycles : busy length of the mult/div unit for a given operation.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    // Forward-select encoding seen by the D-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_GRF = 2'b00,
        FWD_E   = 2'b01,
        FWD_M   = 2'b10,
        FWD_W   = 2'b11
    } fwd_sel_e;

    // Result latency from E: ALU results are ready after E, loads after M,
    // link values (PC+8) are ready as soon as the instruction reaches E.
    localparam int TNEW_PC8  = 0;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LOAD = 2;

    // Operand use point: branches/jr read in D, ALU ops in E, store data in M.
    localparam int TUSE_D = 0;
    localparam int TUSE_E = 1;
    localparam int TUSE_M = 2;

    // Number of busy cycles the mult/div unit needs after leaving E.
    function automatic int md_cycles(input logic is_div,
                                     input int   mult_cyc,
                                     input int   div_cyc);
        return is_div ? div_cyc : mult_cyc;
    endfunction

endpackage : hazard_scoreboard_pkg

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundle between the D-stage decoder/pipeline control (master) and the
//   hazard scoreboard (slave).
//
//   Signalling: there is no valid/ready pair. Every D-stage field is sampled
//   every cycle and qualified by its own enable (d_rs_used, d_rt_used,
//   d_a3 != 0, d_md_start, d_md_use). stall is the only back-pressure: while it
//   is high the master must hold PC and F/D, and the scoreboard inserts a
//   bubble into E. The forward selects are only meaningful when stall is low.
//
//   master -> slave : d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
//                     d_a3, d_tnew, d_md_start, d_md_is_div, d_md_use
//   slave -> master : stall, d_fwd_rs, d_fwd_rt, md_busy
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic              d_rs_used;
    logic              d_rt_used;
    logic [T_W-1:0]    d_rs_tuse;
    logic [T_W-1:0]    d_rt_tuse;
    logic [REG_AW-1:0] d_a3;
    logic [T_W-1:0]    d_tnew;
    logic              d_md_start;
    logic              d_md_is_div;
    logic              d_md_use;

    logic              stall;
    fwd_sel_e          d_fwd_rs;
    fwd_sel_e          d_fwd_rt;
    logic              md_busy;

    modport master (
        output d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
               d_a3, d_tnew, d_md_start, d_md_is_div, d_md_use,
        input  stall, d_fwd_rs, d_fwd_rt, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
               d_a3, d_tnew, d_md_start, d_md_is_div, d_md_use,
        output stall, d_fwd_rs, d_fwd_rt, md_busy
    );

endinterface : hazard_scoreboard_if

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// -----------------------------------------------------------------------------
// md_busy_ctr
//   Busy tracker for the multi-cycle mult/div unit.
//   An accepted start is registered together with its div flag (this is the
//   mult/div instruction sitting in E). One cycle later the counter loads the
//   operation length and then counts down to zero.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-low reset
//     start_i    in   mult/div accepted into E this edge (already gated by stall)
//     is_div_i   in   qualifies start_i: 1 = div/divu, 0 = mult/multu
//     md_busy_o  out  registered start pending or counter non-zero
// -----------------------------------------------------------------------------
module md_busy_ctr
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4     // must hold max(MULT_CYC, DIV_CYC)
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic md_busy_o
);

    logic             start_q,  start_d;
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q  <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            start_q  <= start_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        start_d  = start_i;
        // The div flag is only meaningful alongside a start.
        is_div_d = start_i & is_div_i;
        cnt_d    = cnt_q;
        // A start in E overrides any count still running: the new operation
        // owns HI/LO from here on.
        if (start_q) begin
            cnt_d = CNT_W'(md_cycles(is_div_q, MULT_CYC, DIV_CYC));
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Busy already in the issue cycle, before the counter has loaded.
    assign md_busy_o = start_q | (cnt_q != '0);

endmodule : md_busy_ctr

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Tuse/Tnew stall and forward unit for the F/D/E/M/W pipeline.
//   Keeps {a3, tnew} for the instructions in E, M and W, compares them with the
//   operand requirements of the D-stage instruction and produces the stall and
//   the D-stage forward selects. A sub-block tracks the mult/div busy time.
//
//   Ports
//     clk    in      rising-edge clock
//     reset  in      asynchronous, active-low reset (0 = reset)
//     hz     slave   D-stage fields in; stall, d_fwd_rs, d_fwd_rt, md_busy out
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int T_W      = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  hz
);

    // One pipeline slot: destination register and cycles until its value exists.
    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [T_W-1:0]    tnew;
    } slot_t;

    // Tnew ages by one per stage but never wraps below zero.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    // Only the youngest producer of a register matters: an older match in M is
    // shadowed by a match in E. W is excluded because its value is always
    // available (through forwarding or the GRF) by the time D needs it.
    function automatic logic data_hz(input logic              used,
                                     input logic [REG_AW-1:0] r,
                                     input logic [T_W-1:0]    tuse,
                                     input slot_t             e,
                                     input slot_t             m);
        logic hit;
        hit = 1'b0;
        if (used && (r != '0)) begin
            if (e.a3 == r) begin
                hit = (e.tnew > tuse);
            end else if (m.a3 == r) begin
                hit = (m.tnew > tuse);
            end
        end
        return hit;
    endfunction

    // Youngest stage that already holds the finished value of r.
    function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] r,
                                          input slot_t             e,
                                          input slot_t             m,
                                          input slot_t             w);
        fwd_sel_e sel;
        sel = FWD_GRF;
        if (r != '0) begin
            if ((e.a3 == r) && (e.tnew == '0)) begin
                sel = FWD_E;
            end else if ((m.a3 == r) && (m.tnew == '0)) begin
                sel = FWD_M;
            end else if ((w.a3 == r) && (w.tnew == '0)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    slot_t e_q, e_d;
    slot_t m_q, m_d;
    slot_t w_q, w_d;

    logic  hz_rs;
    logic  hz_rt;
    logic  md_hz;
    logic  stall;
    logic  md_busy;

    // -------------------------------------------------------------------------
    // Stage slots
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    always_comb begin
        e_d = '0;
        // A stalled D instruction does not advance; E receives a bubble.
        if (!stall) begin
            e_d.a3   = hz.d_a3;
            e_d.tnew = hz.d_tnew;
        end
        m_d.a3   = e_q.a3;
        m_d.tnew = sat_dec(e_q.tnew);
        w_d.a3   = m_q.a3;
        w_d.tnew = sat_dec(m_q.tnew);
    end

    // -------------------------------------------------------------------------
    // Hazard detection and forwarding (purely combinational on D inputs)
    // -------------------------------------------------------------------------
    always_comb begin
        hz_rs = data_hz(hz.d_rs_used, hz.d_rs, hz.d_rs_tuse, e_q, m_q);
        hz_rt = data_hz(hz.d_rt_used, hz.d_rt, hz.d_rt_tuse, e_q, m_q);
        // Any HI/LO user, including a second mult/div, waits for the unit.
        md_hz = hz.d_md_use & md_busy;
        stall = hz_rs | hz_rt | md_hz;
    end

    assign hz.stall    = stall;
    assign hz.d_fwd_rs = fwd_pick(hz.d_rs, e_q, m_q, w_q);
    assign hz.d_fwd_rt = fwd_pick(hz.d_rt, e_q, m_q, w_q);
    assign hz.md_busy  = md_busy;

    // -------------------------------------------------------------------------
    // Mult/div busy tracking. The start only counts if the instruction really
    // moves into E, i.e. it is not itself being stalled.
    // -------------------------------------------------------------------------
    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_ctr (
        .clk       (clk),
        .reset     (reset),
        .start_i   (hz.d_md_start & ~stall),
        .is_div_i  (hz.d_md_is_div),
        .md_busy_o (md_busy)
    );

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.REG_AW(5), .T_W(2)) hz ();

    hazard_scoreboard #(
        .REG_AW   (5),
        .T_W      (2),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    // Every instruction that entered E is remembered with its age in stages
    // (0 = E, 1 = M, 2 = W). Its outstanding latency is tnew - age, floored
    // at zero. The mult/div unit is busy from the cycle the op sits in E
    // through the following op-length cycles.
    typedef struct {
        int a3;
        int tnew;
        int age;
    } ent_t;

    ent_t       pipe[$];
    int         cyc;
    int         busy_until;
    logic       exp_stall;
    logic       exp_busy;
    logic [1:0] exp_fwd_rs;
    logic [1:0] exp_fwd_rt;

    function automatic int remaining(input ent_t e);
        return (e.tnew > e.age) ? (e.tnew - e.age) : 0;
    endfunction

    function automatic bit ref_hz(input int r, input bit used, input int tuse);
        int best_age;
        int best_rem;
        best_age = 99;
        best_rem = 0;
        if (!used || r == 0) return 1'b0;
        foreach (pipe[i]) begin
            if (pipe[i].a3 == r && pipe[i].age <= 1 && pipe[i].age < best_age) begin
                best_age = pipe[i].age;
                best_rem = remaining(pipe[i]);
            end
        end
        return (best_age != 99) && (best_rem > tuse);
    endfunction

    function automatic logic [1:0] ref_fwd(input int r);
        int best_age;
        best_age = 99;
        if (r == 0) return 2'b00;
        foreach (pipe[i]) begin
            if (pipe[i].a3 == r && remaining(pipe[i]) == 0 && pipe[i].age < best_age)
                best_age = pipe[i].age;
        end
        return (best_age == 99) ? 2'b00 : 2'(best_age + 1);
    endfunction

    function automatic void model_eval();
        exp_busy   = (cyc <= busy_until);
        exp_stall  = ref_hz(int'(hz.d_rs), hz.d_rs_used, int'(hz.d_rs_tuse))
                   | ref_hz(int'(hz.d_rt), hz.d_rt_used, int'(hz.d_rt_tuse))
                   | (hz.d_md_use & exp_busy);
        exp_fwd_rs = ref_fwd(int'(hz.d_rs));
        exp_fwd_rt = ref_fwd(int'(hz.d_rt));
    endfunction

    function automatic void model_reset();
        pipe.delete();
        cyc        = 0;
        busy_until = -1;
    endfunction

    // Called just after a rising edge, with the D inputs still as they were.
    function automatic void model_commit();
        ent_t n;
        for (int i = pipe.size() - 1; i >= 0; i--) begin
            pipe[i].age = pipe[i].age + 1;
            if (pipe[i].age > 2) pipe.delete(i);
        end
        cyc   = cyc + 1;
        n.a3  = 0;
        n.tnew = 0;
        n.age = 0;
        if (!exp_stall) begin
            n.a3   = int'(hz.d_a3);
            n.tnew = int'(hz.d_tnew);
            if (hz.d_md_start)
                busy_until = cyc + (hz.d_md_is_div ? DIV_CYC : MULT_CYC);
        end
        pipe.push_back(n);
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic set_d(input int rs, input int rt, input bit rs_used, input bit rt_used,
                         input int rs_tuse, input int rt_tuse, input int a3, input int tnew,
                         input bit md_start, input bit md_is_div, input bit md_use);
        hz.d_rs        = 5'(rs);
        hz.d_rt        = 5'(rt);
        hz.d_rs_used   = rs_used;
        hz.d_rt_used   = rt_used;
        hz.d_rs_tuse   = 2'(rs_tuse);
        hz.d_rt_tuse   = 2'(rt_tuse);
        hz.d_a3        = 5'(a3);
        hz.d_tnew      = 2'(tnew);
        hz.d_md_start  = md_start;
        hz.d_md_is_div = md_is_div;
        hz.d_md_use    = md_use;
    endtask

    task automatic set_nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Let combinational outputs settle and refresh the expectations.
    task automatic settle();
        #1;
        model_eval();
    endtask

    // One clock: inputs are changed and sampled in the low phase only.
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic drain();
        set_nop();
        repeat (3) tick();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        // Aggressive D inputs: nothing is tracked, so nothing may fire.
        set_d(1, 1, 1, 1, 0, 0, 3, 2, 1, 1, 1);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL reset_stall: got %0b exp 0", hz.stall); errors++; end
        checks++; if (hz.md_busy !== 1'b0) begin $display("FAIL reset_busy: got %0b exp 0", hz.md_busy); errors++; end
        checks++; if (hz.d_fwd_rs !== 2'b00) begin $display("FAIL reset_fwd_rs: got %0b exp 00", hz.d_fwd_rs); errors++; end
        checks++; if (hz.d_fwd_rt !== 2'b00) begin $display("FAIL reset_fwd_rt: got %0b exp 00", hz.d_fwd_rt); errors++; end
        @(negedge clk);
        reset = 1'b1;
        set_nop();
        settle();
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL post_reset_stall: got %0b exp 0", hz.stall); errors++; end
    endtask

    task automatic test_load_use();
        int n;
        drain();
        // lw $1, 0($2): rs read in E
        set_d(2, 0, 1, 0, TUSE_E, 0, 1, TNEW_LOAD, 0, 0, 0);
        settle();
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL lw_issue_stall: got %0b exp 0", hz.stall); errors++; end
        tick();
        // beq $1, $2 reads both in D
        set_d(1, 2, 1, 1, TUSE_D, TUSE_D, 0, 0, 0, 0, 0);
        settle();
        n = 0;
        while (hz.stall === 1'b1 && n < 40) begin
            checks++; if (hz.stall !== exp_stall) begin $display("FAIL lu_stall_model: got %0b exp %0b", hz.stall, exp_stall); errors++; end
            tick();
            settle();
            n++;
        end
        checks++; if (n !== 2) begin $display("FAIL lu_stall_cycles: got %0d exp 2", n); errors++; end
        // The load has reached W with its value ready.
        checks++; if (hz.d_fwd_rs !== 2'b11) begin $display("FAIL lu_fwd_rs: got %0b exp 11", hz.d_fwd_rs); errors++; end
        checks++; if (hz.d_fwd_rt !== 2'b00) begin $display("FAIL lu_fwd_rt: got %0b exp 00", hz.d_fwd_rt); errors++; end
        tick();
    endtask

    task automatic test_alu_fwd();
        drain();
        // addu $3
        set_d(0, 0, 0, 0, 0, 0, 3, TNEW_ALU, 0, 0, 0);
        tick();
        // addu $4, $3, $3
        set_d(3, 3, 1, 1, TUSE_E, TUSE_E, 4, TNEW_ALU, 0, 0, 0);
        settle();
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL alu_stall: got %0b exp 0", hz.stall); errors++; end
        checks++; if (hz.d_fwd_rs !== 2'b00) begin $display("FAIL alu_fwd_rs_early: got %0b exp 00", hz.d_fwd_rs); errors++; end
        tick();
        // Next consumer of $3: producer now in M with tnew 0.
        set_d(3, 0, 1, 0, TUSE_E, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (hz.d_fwd_rs !== 2'b10) begin $display("FAIL alu_fwd_rs_m: got %0b exp 10", hz.d_fwd_rs); errors++; end
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL alu_stall2: got %0b exp 0", hz.stall); errors++; end
        tick();
    endtask

    task automatic test_fwd_priority();
        drain();
        set_d(0, 0, 0, 0, 0, 0, 5, TNEW_PC8, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 5, TNEW_PC8, 0, 0, 0);
        tick();
        // jr $5 with rt also $5: both selects must agree on E.
        set_d(5, 5, 1, 1, TUSE_D, TUSE_D, 0, 0, 0, 0, 0);
        settle();
        checks++; if (hz.d_fwd_rs !== 2'b01) begin $display("FAIL prio_fwd_rs: got %0b exp 01", hz.d_fwd_rs); errors++; end
        checks++; if (hz.d_fwd_rt !== 2'b01) begin $display("FAIL prio_fwd_rt: got %0b exp 01", hz.d_fwd_rt); errors++; end
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL prio_stall: got %0b exp 0", hz.stall); errors++; end
        tick();
        // E now holds a3 = 0; $0 never forwards, $5 comes from M.
        set_d(0, 5, 1, 1, TUSE_D, TUSE_D, 0, 0, 0, 0, 0);
        settle();
        checks++; if (hz.d_fwd_rs !== 2'b00) begin $display("FAIL zero_fwd_rs: got %0b exp 00", hz.d_fwd_rs); errors++; end
        checks++; if (hz.d_fwd_rt !== 2'b10) begin $display("FAIL zero_fwd_rt: got %0b exp 10", hz.d_fwd_rt); errors++; end
        tick();
    endtask

    task automatic test_md_busy(input bit is_div, input int exp_cycles);
        int n;
        drain();
        set_d(1, 2, 1, 1, TUSE_E, TUSE_E, 0, 0, 1, is_div, 1);
        settle();
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL md_issue_stall: got %0b exp 0", hz.stall); errors++; end
        tick();
        // mflo $8
        set_d(0, 0, 0, 0, 0, 0, 8, TNEW_ALU, 0, 0, 1);
        settle();
        n = 0;
        while (hz.stall === 1'b1 && n < 40) begin
            checks++; if (hz.md_busy !== 1'b1) begin $display("FAIL md_busy_during: got %0b exp 1 (n %0d)", hz.md_busy, n); errors++; end
            tick();
            settle();
            n++;
        end
        checks++; if (n !== exp_cycles) begin $display("FAIL md_stall_cycles: got %0d exp %0d", n, exp_cycles); errors++; end
        checks++; if (hz.md_busy !== 1'b0) begin $display("FAIL md_busy_release: got %0b exp 0", hz.md_busy); errors++; end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        drain();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);   // mult
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);   // div, held until unit free
        settle();
        n = 0;
        while (hz.stall === 1'b1 && n < 40) begin tick(); settle(); n++; end
        checks++; if (n !== 1 + MULT_CYC) begin $display("FAIL b2b_div_wait: got %0d exp %0d", n, 1 + MULT_CYC); errors++; end
        tick();
        set_d(0, 0, 0, 0, 0, 0, 9, TNEW_ALU, 0, 0, 1);   // mflo
        settle();
        n = 0;
        while (hz.stall === 1'b1 && n < 40) begin tick(); settle(); n++; end
        checks++; if (n !== 1 + DIV_CYC) begin $display("FAIL b2b_mflo_wait: got %0d exp %0d", n, 1 + DIV_CYC); errors++; end
        tick();
    endtask

    task automatic test_reset_mid();
        drain();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);   // div
        tick();
        set_nop();
        repeat (6) tick();
        set_d(0, 0, 0, 0, 0, 0, 1, TNEW_LOAD, 0, 0, 0);   // lw $1
        tick();
        // div counter is at 4 now; beq $1 that also touches HI/LO
        set_d(1, 1, 1, 1, TUSE_D, TUSE_D, 0, 0, 0, 0, 1);
        settle();
        checks++; if (hz.stall !== 1'b1) begin $display("FAIL mid_pre_stall: got %0b exp 1", hz.stall); errors++; end
        checks++; if (hz.md_busy !== 1'b1) begin $display("FAIL mid_pre_busy: got %0b exp 1", hz.md_busy); errors++; end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL mid_rst_stall: got %0b exp 0", hz.stall); errors++; end
        checks++; if (hz.md_busy !== 1'b0) begin $display("FAIL mid_rst_busy: got %0b exp 0", hz.md_busy); errors++; end
        checks++; if (hz.d_fwd_rs !== 2'b00) begin $display("FAIL mid_rst_fwd: got %0b exp 00", hz.d_fwd_rs); errors++; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        settle();
        checks++; if (hz.stall !== 1'b0) begin $display("FAIL mid_rel_stall: got %0b exp 0", hz.stall); errors++; end
        checks++; if (hz.md_busy !== 1'b0) begin $display("FAIL mid_rel_busy: got %0b exp 0", hz.md_busy); errors++; end
        tick();
    endtask

    task automatic test_random();
        int r;
        drain();
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 11);
            set_d($urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 3),
                  r == 0, 1'($urandom_range(0, 1)), r <= 1);
            settle();
            checks++; if (hz.stall !== exp_stall) begin $display("FAIL rnd_stall: got %0b exp %0b (iter %0d)", hz.stall, exp_stall, k); errors++; end
            checks++; if (hz.md_busy !== exp_busy) begin $display("FAIL rnd_busy: got %0b exp %0b (iter %0d)", hz.md_busy, exp_busy, k); errors++; end
            checks++; if (hz.d_fwd_rs !== exp_fwd_rs) begin $display("FAIL rnd_fwd_rs: got %0b exp %0b (iter %0d)", hz.d_fwd_rs, exp_fwd_rs, k); errors++; end
            checks++; if (hz.d_fwd_rt !== exp_fwd_rt) begin $display("FAIL rnd_fwd_rt: got %0b exp %0b (iter %0d)", hz.d_fwd_rt, exp_fwd_rt, k); errors++; end
            tick();
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_fwd_priority();
        test_md_busy(1'b1, 1 + DIV_CYC);
        test_md_busy(1'b0, 1 + MULT_CYC);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_scoreboard
